// File: rtl/gf8_reduce_acc.sv
// Reduces a 15-coefficient GF(2) product modulo {1,POLY} and XOR-accumulates ACC_LEN results.
// Optional GF8_ACC_FLUSH_EN adds an in_last input that forces the output path early.
module gf8_reduce_acc #(
  parameter logic [7:0]  POLY    = 8'h1B,
  parameter int unsigned ACC_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] hi,
  input  logic [6:0] lo,
`ifdef GF8_ACC_FLUSH_EN
  input  logic       in_last,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StRed, StAcc, StOut} state_e;

  localparam logic [7:0]  CntLast  = 8'(ACC_LEN - 1);
  localparam logic [14:0] PolyFull = {6'd0, 1'b1, POLY};

  state_e      state;
  logic [14:0] r;
  logic [14:0] r_next;
  logic [7:0]  acc;
  logic [7:0]  cnt;
  logic [2:0]  step;
  logic        flush;

`ifdef GF8_ACC_FLUSH_EN
  logic last;
  assign flush = last;
`else
  assign flush = 1'b0;
`endif

  // One long-division step: clear coefficient 8+step by subtracting the shifted polynomial.
  always_comb begin
    r_next = r;
    if (r[4'd8 + {1'b0, step}]) begin
      r_next = r ^ (PolyFull << step);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      r         <= '0;
      acc       <= '0;
      cnt       <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef GF8_ACC_FLUSH_EN
      last      <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            r        <= {hi, lo};
            step     <= 3'd6;
            state    <= StRed;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef GF8_ACC_FLUSH_EN
            last     <= in_last;
`endif
          end
        end
        StRed: begin
          r <= r_next;
          if (step == 3'd0) begin
            state <= StAcc;
          end else begin
            step <= step - 3'd1;
          end
        end
        StAcc: begin
          if (cnt == CntLast || flush) begin
            out_data  <= acc ^ r[7:0];
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= StOut;
          end else begin
            acc      <= acc ^ r[7:0];
            cnt      <= cnt + 8'd1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gf8_reduce_acc.sv
// Directed bench for gf8_reduce_acc: one instance with ACC_LEN=1, one with ACC_LEN=4.
module tb_gf8_reduce_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, busy1;
  logic [7:0] hi1 = '0, out_data1;
  logic [6:0] lo1 = '0;
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, busy4;
  logic [7:0] hi4 = '0, out_data4;
  logic [6:0] lo4 = '0;
`ifdef GF8_ACC_FLUSH_EN
  logic       in_last1 = 1'b0;
  logic       in_last4 = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gf8_reduce_acc #(.POLY(8'h1B), .ACC_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .hi(hi1), .lo(lo1),
`ifdef GF8_ACC_FLUSH_EN
    .in_last(in_last1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
  );

  gf8_reduce_acc #(.POLY(8'h1B), .ACC_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .hi(hi4), .lo(lo4),
`ifdef GF8_ACC_FLUSH_EN
    .in_last(in_last4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single beat on the ACC_LEN=1 instance, checking latency and result, then handshake.
  task automatic beat1(input logic [7:0] h, input logic [6:0] l, input logic [7:0] exp,
                       input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready1, 1);
    in_valid1 = 1'b1; hi1 = h; lo1 = l;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 1;
    check({tag, "_busy"}, busy1, 1);
    while (!out_valid1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_data"}, out_data1, exp);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({tag, "_vld_drop"}, out_valid1, 0);
  endtask

  // Beat on the ACC_LEN=4 instance; is_out says whether this beat should produce the result.
  task automatic beat4(input logic [7:0] h, input logic [6:0] l, input logic is_out,
                       input logic [7:0] exp, input string tag);
    int bad;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready4, 1);
    in_valid4 = 1'b1; hi4 = h; lo4 = l;
    @(negedge clk);
    in_valid4 = 1'b0;
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (in_ready4 || out_valid4 || !busy4) bad++;
      @(negedge clk);
    end
    check({tag, "_busy_window"}, bad, 0);
    if (is_out) begin
      check({tag, "_vld"}, out_valid4, 1);
      check({tag, "_data"}, out_data4, exp);
      check({tag, "_rdy_out"}, in_ready4, 0);
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      check({tag, "_vld_drop"}, out_valid4, 0);
      check({tag, "_rdy_back"}, in_ready4, 1);
    end else begin
      check({tag, "_novld"}, out_valid4, 0);
      check({tag, "_rdy_back"}, in_ready4, 1);
    end
  endtask

  initial begin
    int bad;
    int lat;
    #12;
    check("rst_rdy1", in_ready1, 1);
    check("rst_vld1", out_valid1, 0);
    check("rst_data1", out_data1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_rdy4", in_ready4, 1);
    check("rst_busy4", busy4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ACC_LEN=1 directed products
    beat1(8'h56, 7'h79, 8'hC1, "aes_mul");
    beat1(8'h02, 7'h00, 8'h1B, "x8");
    beat1(8'h00, 7'h55, 8'h55, "noreduce");

    // Output stall with in_valid held high meanwhile
    beat1(8'h00, 7'h01, 8'h01, "pre_stall");
    @(negedge clk);
    in_valid1 = 1'b1; hi1 = 8'h56; lo1 = 7'h79;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", lat, 9);
    in_valid1 = 1'b1; hi1 = 8'h02; lo1 = 7'h00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid1 || out_data1 !== 8'hC1 || in_ready1) bad++;
      @(negedge clk);
    end
    check("stall_hold", bad, 0);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("stall_idle_rdy", in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("stall_next_acc", in_ready1, 0);
    lat = 1;
    while (!out_valid1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_next_lat", lat, 9);
    check("stall_next_data", out_data1, 8'h1B);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;

    // ACC_LEN=4 accumulation: C1 ^ 1B ^ 0 ^ 0
    beat4(8'h56, 7'h79, 1'b0, 8'h00, "acc_b0");
    beat4(8'h02, 7'h00, 1'b0, 8'h00, "acc_b1");
    beat4(8'h00, 7'h00, 1'b0, 8'h00, "acc_b2");
    beat4(8'h00, 7'h00, 1'b1, 8'hDA, "acc_b3");

    // Reset during RED step 3 of the second beat
    beat4(8'h56, 7'h79, 1'b0, 8'h00, "rst_b0");
    @(negedge clk);
    in_valid4 = 1'b1; hi4 = 8'h02; lo4 = 7'h00;
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", in_ready4, 1);
    check("midrst_busy", busy4, 0);
    check("midrst_vld", out_valid4, 0);
    check("midrst_data", out_data4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat4(8'h02, 7'h00, 1'b0, 8'h00, "post_b0");
    beat4(8'h00, 7'h55, 1'b0, 8'h00, "post_b1");
    beat4(8'h00, 7'h00, 1'b0, 8'h00, "post_b2");
    beat4(8'h00, 7'h00, 1'b1, 8'h4E, "post_b3");

`ifdef GF8_ACC_FLUSH_EN
    in_last4 = 1'b0;
    beat4(8'h56, 7'h79, 1'b0, 8'h00, "flush_b0");
    in_last4 = 1'b1;
    beat4(8'h02, 7'h00, 1'b1, 8'hDA, "flush_b1");
    in_last4 = 1'b0;
    beat4(8'h02, 7'h00, 1'b0, 8'h00, "aflush_b0");
    beat4(8'h00, 7'h55, 1'b0, 8'h00, "aflush_b1");
    beat4(8'h00, 7'h00, 1'b0, 8'h00, "aflush_b2");
    beat4(8'h00, 7'h00, 1'b1, 8'h4E, "aflush_b3");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
